// File: rtl/ins_fetch.sv
// Instruction fetch unit: reads bytes from program memory over a req/ack handshake,
// buffers them in a small prefetch FIFO and hands them to the instruction register
// on request. A branch redirects the fetch PC and discards everything in flight.
module ins_fetch #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              fetch_req,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [7:0]        ins_reg,
  output logic              loadIR,
  output logic [ADDR_W-1:0] pc,
  output logic              stall
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [7:0]          data_q [DEPTH];
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [7:0]          ins_reg_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                load_ir_q;
  logic                push, pop, empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + PtrW'(1);
  endfunction

  assign empty = (count_q == '0);
  // Branch suppresses delivery so nothing stale reaches the instruction register.
  assign pop   = fetch_req && !branch && !empty;
  assign stall = fetch_req && empty;

  // Memory request FSM and fetch PC next-state.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A same-cycle pop frees a slot, so a full FIFO being drained may still issue.
        if (!branch && ((count_q != CntFull) || pop)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (branch) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
          end else begin
            state_d = StDiscard;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          mem_req_d  = 1'b0;
          state_d    = StIdle;
        end
      end
      StDiscard: begin
        // Request cannot be withdrawn; wait for its ack and drop the data.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (branch) fetch_pc_d = branch_addr;
  end

  // FIFO pointer and occupancy next-state; a branch flushes everything.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (branch) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_data;
      addr_q[wr_ptr_q] <= mem_addr_q;
    end
  end

  // Delivery to the instruction register: one-cycle loadIR pulse per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_reg_q <= '0;
      pc_q      <= RESET_PC;
      load_ir_q <= 1'b0;
    end else begin
      load_ir_q <= pop;
      if (pop) begin
        ins_reg_q <= data_q[rd_ptr_q];
        pc_q      <= addr_q[rd_ptr_q];
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ins_reg  = ins_reg_q;
  assign pc       = pc_q;
  assign loadIR   = load_ir_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios followed by a random phase, all checked
// against a queue-based reference model and a reactive memory responder.
module tb_ins_fetch;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2;
  localparam logic [7:0]  RPC   = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req, mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_data = 8'h00;
  logic       fetch_req = 1'b0, branch = 1'b0;
  logic [7:0] branch_addr = 8'h00;
  logic [7:0] ins_reg, pc;
  logic       loadIR, stall;

  always #5 clk = ~clk;

  ins_fetch #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .fetch_req(fetch_req), .branch(branch),
    .branch_addr(branch_addr), .ins_reg(ins_reg), .loadIR(loadIR), .pc(pc), .stall(stall)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO as a queue of {addr, data}, plus request bookkeeping.
  typedef struct packed {logic [7:0] a; logic [7:0] d;} ent_t;
  ent_t       mq[$];
  logic [7:0] m_fpc, m_addr, m_ins, m_pc;
  logic       m_req, m_stale, m_load;

  // Memory responder state.
  int         wait_cnt = 0, ack_dly = 1, n_reqs = 0;
  bit         prev_req = 0, rand_dly = 0;
  logic [7:0] last_req_addr = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc = RPC; m_addr = RPC; m_ins = 8'h00; m_pc = RPC;
    m_req = 0; m_stale = 0; m_load = 0;
    wait_cnt = 0; prev_req = 0; mem_ack = 0;
  endtask

  task automatic model_step();
    int   sz;
    bit   pp;
    ent_t e;
    sz = mq.size();
    pp = fetch_req && !branch && (sz > 0);
    if (pp) begin
      e = mq.pop_front();
      m_ins = e.d; m_pc = e.a; m_load = 1;
    end else begin
      m_load = 0;
    end
    if (m_req) begin
      if (mem_ack) begin
        if (!branch && !m_stale) begin
          mq.push_back({m_addr, mem_data});
          m_fpc = m_fpc + 8'd1;
        end
        m_req = 0; m_stale = 0;
      end else if (branch) begin
        m_stale = 1;
      end
    end else if (!branch && (sz - int'(pp)) < int'(DEPTH)) begin
      m_req = 1; m_addr = m_fpc;
    end
    if (branch) begin
      mq.delete();
      m_fpc = branch_addr;
    end
  endtask

  task automatic compare_regs();
    chk("loadIR", loadIR, m_load);
    chk("ins_reg", ins_reg, m_ins);
    chk("pc", pc, m_pc);
    chk("mem_req", mem_req, m_req);
    chk("mem_addr", mem_addr, m_addr);
  endtask

  task automatic respond();
    if (mem_req && !prev_req) begin
      n_reqs++;
      last_req_addr = mem_addr;
      if (rand_dly) ack_dly = $urandom_range(1, 4);
    end
    prev_req = mem_req;
    if (mem_req) wait_cnt++; else wait_cnt = 0;
    mem_ack  = mem_req && (wait_cnt >= ack_dly);
    mem_data = mem_ack ? (mem_addr ^ 8'hA5) : 8'($urandom);
  endtask

  // One clock: starts and ends at a falling edge with inputs already driven.
  task automatic tick();
    #1;
    chk("stall", stall, fetch_req && (mq.size() == 0));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_regs();
    branch = 0;
    respond();
  endtask

  initial begin
    int   n0, loads;
    bit   got, got_req;
    logic [7:0] exp_pc [4];
    logic [7:0] req_addr;

    model_reset();
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, RPC);
    chk("rst_loadIR", loadIR, 1'b0);
    chk("rst_ins_reg", ins_reg, 8'h00);
    chk("rst_pc", pc, RPC);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // 1: no consumer, fast acks -> only addresses 0 and 1 requested.
    ack_dly = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("t1_req_count", n_reqs, 2);
    chk("t1_idle_full", mem_req, 1'b0);

    // 2: single fetch pops the head; freed slot immediately triggers request 2.
    fetch_req = 1;
    tick();
    fetch_req = 0;
    chk("t2_loadIR", loadIR, 1'b1);
    chk("t2_ins_reg", ins_reg, 8'hA5);
    chk("t2_pc", pc, 8'h00);
    chk("t2_req", mem_req, 1'b1);
    chk("t2_req_addr", mem_addr, 8'h02);
    tick();
    chk("t2_pulse_end", loadIR, 1'b0);
    fetch_req = 1;
    for (int i = 0; i < 6; i++) tick();

    // 3: branch while a slow request is outstanding.
    ack_dly = 3;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mem_req && (wait_cnt == 1);
    end
    chk("t3_wait_reached", got, 1'b1);
    branch = 1; branch_addr = 8'h40;
    n0 = n_reqs; got = 0; got_req = 0; req_addr = 8'h00;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (!got_req && n_reqs > n0) begin got_req = 1; req_addr = last_req_addr; end
      got = loadIR;
    end
    chk("t3_first_req_addr", req_addr, 8'h40);
    chk("t3_load_seen", got, 1'b1);
    chk("t3_pc", pc, 8'h40);
    chk("t3_ins_reg", ins_reg, 8'h40 ^ 8'hA5);

    // 4: branch near the top of memory -> PC wraps.
    ack_dly = 1;
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    branch = 1; branch_addr = 8'hFE;
    loads = 0;
    for (int i = 0; i < 40 && loads < 4; i++) begin
      tick();
      if (loadIR) begin
        chk("t4_pc_seq", pc, exp_pc[loads]);
        chk("t4_ins_seq", ins_reg, exp_pc[loads] ^ 8'hA5);
        loads++;
      end
    end
    chk("t4_load_count", loads, 4);

    // 5: consumer starved while memory holds off.
    ack_dly = 1000;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (mq.size() == 0) && m_req;
    end
    chk("t5_starved", got, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall", stall, 1'b1);
      chk("t5_no_load", loadIR, 1'b0);
    end
    mem_ack = 1; mem_data = mem_addr ^ 8'hA5;
    req_addr = mem_addr;
    tick();
    chk("t5_ack_no_bypass", loadIR, 1'b0);
    chk("t5_stall_after_push", stall, 1'b0);
    tick();
    chk("t5_load", loadIR, 1'b1);
    chk("t5_load_pc", pc, req_addr);
    loads = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (loadIR) loads++;
    end
    chk("t5_single_pulse", loads, 0);

    // 6: asynchronous reset mid-request.
    fetch_req = 0;
    chk("t6_mid_wait", mem_req, 1'b1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_mem_addr", mem_addr, RPC);
    chk("t6_loadIR", loadIR, 1'b0);
    chk("t6_ins_reg", ins_reg, 8'h00);
    chk("t6_pc", pc, RPC);
    chk("t6_stall", stall, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    ack_dly = 1;
    n0 = n_reqs; got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      got = (n_reqs > n0);
    end
    chk("t6_req_seen", got, 1'b1);
    chk("t6_first_addr", last_req_addr, RPC);

    // Random phase: random consumer, branches and ack latencies.
    rand_dly = 1;
    for (int i = 0; i < 400; i++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      branch      = ($urandom_range(0, 19) == 0);
      branch_addr = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
